// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - multiplexed 7-segment scan decoder to BCD frames; optional macro FND_SCAN_DP_EN
module fnd_scan_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_data,
  output logic [3:0]  dp_data,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        seg_error,
  output logic        scan_lost
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   cnt, cnt_nxt;
  logic [3:0]      an_q;
  logic [7:0]      seg_q;
  logic [7:0]      seg_cmp;
  logic            an_valid, an_same, seg_same, capture;
  logic [1:0]      slot;
  logic [3:0]      digit;
  logic            digit_err, digit_dp;
  logic [3:0][3:0] shadow_bcd;
  logic [3:0]      shadow_dp, shadow_err, mask;
  logic [3:0]      mask_nxt, err_nxt;
  logic [TW-1:0]   tcnt;
  logic            first_frame;
  logic            frame_load;
  logic            timeout_hit;

  // The dp bit only takes part in stability and capture when the feature is built in
`ifdef FND_SCAN_DP_EN
  assign seg_cmp  = seg;
  assign digit_dp = ~seg[7];
`else
  assign seg_cmp  = seg & 8'h7F;
  assign digit_dp = 1'b0;
`endif

  assign an_same     = (an == an_q);
  assign seg_same    = (seg_cmp == seg_q);
  assign frame_load  = (mask == 4'hF);
  assign timeout_hit = !capture && (tcnt == TIMEOUT_MAX - TW'(1));

  // Slot select: exactly one active-low enable marks a valid digit
  always_comb begin
    an_valid = 1'b1;
    slot     = 2'd0;
    case (an)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  // Segment pattern to digit decode; unknown patterns flag an error
  always_comb begin
    digit     = 4'hF;
    digit_err = 1'b0;
    case (seg[6:0])
      7'h40: digit = 4'h0;
      7'h79: digit = 4'h1;
      7'h24: digit = 4'h2;
      7'h30: digit = 4'h3;
      7'h19: digit = 4'h4;
      7'h12: digit = 4'h5;
      7'h02: digit = 4'h6;
      7'h78: digit = 4'h7;
      7'h00: digit = 4'h8;
      7'h10: digit = 4'h9;
      7'h7F: digit = 4'hB;
      default: digit_err = 1'b1;
    endcase
  end

  // Settle FSM next state; capture fires when the stable count reaches SETTLE_CYC
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (an_valid) begin
          state_nxt = SETTLE;
          cnt_nxt   = SW'(1);
        end
      end
      SETTLE: begin
        if (an_same && seg_same) begin
          cnt_nxt = cnt + SW'(1);
        end else if (an_valid) begin
          cnt_nxt = SW'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      HELD: begin
        if (!an_same) begin
          if (an_valid) begin
            state_nxt = SETTLE;
            cnt_nxt   = SW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt == SETTLE && cnt_nxt == SETTLE_MAX) begin
      capture   = 1'b1;
      state_nxt = HELD;
    end
  end

  // Mask/error bookkeeping: a load clears first so a same-cycle capture lands in the next frame
  always_comb begin
    mask_nxt = mask;
    err_nxt  = shadow_err;
    if (frame_load) begin
      mask_nxt = '0;
      err_nxt  = '0;
    end
    if (capture) begin
      mask_nxt[slot] = 1'b1;
      err_nxt[slot]  = digit_err;
    end
    if (timeout_hit) begin
      mask_nxt = '0;
    end
  end

  // Previous-cycle copies of the scan inputs for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '0;
      seg_q <= '0;
    end else begin
      an_q  <= an;
      seg_q <= seg_cmp;
    end
  end

  // FSM state and settle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Shadow capture, frame load and scan-loss timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_bcd    <= '0;
      shadow_dp     <= '0;
      shadow_err    <= '0;
      mask          <= '0;
      bcd_data      <= '0;
      dp_data       <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      seg_error     <= 1'b0;
      scan_lost     <= 1'b0;
      tcnt          <= '0;
      first_frame   <= 1'b1;
    end else begin
      frame_valid   <= frame_load;
      frame_changed <= 1'b0;
      if (frame_load) begin
        bcd_data      <= shadow_bcd;
        dp_data       <= shadow_dp;
        seg_error     <= |shadow_err;
        frame_changed <= first_frame || (shadow_bcd != bcd_data);
        first_frame   <= 1'b0;
      end
      if (capture) begin
        shadow_bcd[slot] <= digit;
        shadow_dp[slot]  <= digit_dp;
      end
      mask       <= mask_nxt;
      shadow_err <= err_nxt;
      if (capture) begin
        tcnt      <= '0;
        scan_lost <= 1'b0;
      end else if (tcnt != TIMEOUT_MAX) begin
        tcnt <= tcnt + TW'(1);
        if (timeout_hit) begin
          scan_lost <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb/tb_fnd_scan_decoder.sv - self-checking bench for fnd_scan_decoder with a behavioural frame model
module tb_fnd_scan_decoder;

  localparam int S = 16;
  localparam int T = 100;
`ifdef FND_SCAN_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seg = 8'hFF;
  logic [3:0]  an = 4'hF;
  logic [15:0] bcd_data;
  logic [3:0]  dp_data;
  logic        frame_valid, frame_changed, seg_error, scan_lost;

  fnd_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .bcd_data(bcd_data), .dp_data(dp_data), .frame_valid(frame_valid),
    .frame_changed(frame_changed), .seg_error(seg_error), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  // Model: a digit is taken when the last S samples hold the same valid an and seg,
  // at most once per continuous presence of that an value
  logic [4:0]  dec_tab [128];
  logic [3:0]  hist_an [$];
  logic [7:0]  hist_seg [$];
  logic [3:0]  run_an = 4'hF;
  bit          got = 1'b0;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp = '0, m_er = '0, m_have = '0;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dpd = '0;
  logic        m_fv = 1'b0, m_fc = 1'b0, m_se = 1'b0, m_lost = 1'b0;
  bit          m_first = 1'b1;
  int          since = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    logic [7:0] sc;
    logic       same;
    int         idx;
    logic [4:0] d;
    cyc = cyc + 1;
    if (reset) begin
      hist_an.delete();
      hist_seg.delete();
      run_an = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] = '0;
      m_dp = '0; m_er = '0; m_have = '0; m_bcd = '0; m_dpd = '0;
      m_fv = 1'b0; m_fc = 1'b0; m_se = 1'b0; m_lost = 1'b0;
      m_first = 1'b1;
      since = 0;
    end else begin
      sc = DP_EN ? seg : {1'b0, seg[6:0]};
      if (an != run_an) got = 1'b0;
      run_an = an;
      hist_an.push_back(an);
      hist_seg.push_back(sc);
      if (hist_an.size() > S) begin
        void'(hist_an.pop_front());
        void'(hist_seg.pop_front());
      end
      idx = -1;
      for (int i = 0; i < 4; i++) if (an == (4'hF ^ (4'h1 << i))) idx = i;
      same = (hist_an.size() == S);
      for (int i = 0; i < hist_an.size(); i++)
        if (hist_an[i] != an || hist_seg[i] != sc) same = 1'b0;
      m_fv = 1'b0;
      m_fc = 1'b0;
      if (m_have == 4'hF) begin
        m_fc = m_first || ({m_dig[3], m_dig[2], m_dig[1], m_dig[0]} != m_bcd);
        m_bcd = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        m_dpd = m_dp;
        m_se = |m_er;
        m_fv = 1'b1;
        m_first = 1'b0;
        m_have = '0;
        m_er = '0;
      end
      if (idx >= 0 && !got && same) begin
        d = dec_tab[seg[6:0]];
        got = 1'b1;
        m_dig[idx] = d[3:0];
        m_er[idx] = d[4];
        m_dp[idx] = DP_EN ? ~seg[7] : 1'b0;
        m_have[idx] = 1'b1;
        since = 0;
        m_lost = 1'b0;
      end else if (since < T) begin
        since++;
        if (since == T) begin
          m_lost = 1'b1;
          m_have = '0;
        end
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  int          fv_count = 0;
  logic [15:0] last_bcd = '0;
  logic [3:0]  last_dp = '0;
  logic        last_chg = 1'b0, last_err = 1'b0;
  int          last_fv_cyc = 0;
  int          fv0, s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    check("outputs", {8'h0, bcd_data, dp_data, frame_valid, frame_changed, seg_error, scan_lost},
          {8'h0, m_bcd, m_dpd, m_fv, m_fc, m_se, m_lost});
    if (frame_valid === 1'b1) begin
      fv_count++;
      last_bcd = bcd_data;
      last_dp = dp_data;
      last_chg = frame_changed;
      last_err = seg_error;
      last_fv_cyc = cyc;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) begin
      @(negedge clk);
      cmp_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      cmp_all();
    end
    reset = 1'b0;
  endtask

  task automatic scan(input logic [7:0] s0_, input logic [7:0] s1_, input logic [7:0] s2_,
                      input logic [7:0] s3_);
    hold(4'b1110, s0_, 20);
    hold(4'b1101, s1_, 20);
    hold(4'b1011, s2_, 20);
    hold(4'b0111, s3_, 20);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) dec_tab[i] = 5'h1F;
    dec_tab[7'h40] = 5'h00; dec_tab[7'h79] = 5'h01; dec_tab[7'h24] = 5'h02;
    dec_tab[7'h30] = 5'h03; dec_tab[7'h19] = 5'h04; dec_tab[7'h12] = 5'h05;
    dec_tab[7'h02] = 5'h06; dec_tab[7'h78] = 5'h07; dec_tab[7'h00] = 5'h08;
    dec_tab[7'h10] = 5'h09; dec_tab[7'h7F] = 5'h0B;

    do_reset();
    check("reset_state", {8'h0, bcd_data, dp_data, frame_valid, frame_changed, seg_error, scan_lost}, 32'h0);

    fv0 = fv_count;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    hold(4'hF, 8'hFF, 5);
    check("frame1_count", 32'(fv_count - fv0), 32'd1);
    check("frame1_bcd", {16'h0, last_bcd}, 32'h4321);
    check("frame1_err", {31'h0, last_err}, 32'h0);
    check("frame1_changed", {31'h0, last_chg}, 32'h1);

    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    hold(4'hF, 8'hFF, 5);
    check("frame2_count", 32'(fv_count - fv0), 32'd2);
    check("frame2_bcd", {16'h0, last_bcd}, 32'h4321);
    check("frame2_changed", {31'h0, last_chg}, 32'h0);

    do_reset();
    hold(4'b1110, 8'hF9, 20);
    hold(4'b1101, 8'hA4, 20);
    hold(4'b1011, 8'hB0, 20);
    hold(4'b0111, 8'hF9, 10);
    hold(4'b0111, 8'hA4, 10);
    hold(4'b0111, 8'hF9, 10);
    hold(4'b0111, 8'hA4, 10);
    s0 = cyc;
    fv0 = fv_count;
    hold(4'b0111, 8'h99, 16);
    check("glitch_no_early_frame", 32'(fv_count - fv0), 32'd0);
    hold(4'b0111, 8'h99, 1);
    check("glitch_frame_count", 32'(fv_count - fv0), 32'd1);
    check("glitch_frame_cycle", 32'(last_fv_cyc - s0), 32'd17);
    check("glitch_frame_bcd", {16'h0, last_bcd}, 32'h4321);

    hold(4'hF, 8'hFF, 3);
    scan(8'hF9, 8'h6A, 8'hB0, 8'h99);
    hold(4'hF, 8'hFF, 5);
    check("bad_seg_bcd", {16'h0, last_bcd}, 32'h43F1);
    check("bad_seg_err", {31'h0, last_err}, 32'h1);

    do_reset();
    hold(4'hF, 8'hFF, 99);
    check("lost_before_timeout", {31'h0, scan_lost}, 32'h0);
    hold(4'hF, 8'hFF, 1);
    check("lost_at_timeout", {31'h0, scan_lost}, 32'h1);
    hold(4'hF, 8'hFF, 30);
    check("lost_saturated", {31'h0, scan_lost}, 32'h1);
    hold(4'b1110, 8'hF9, 15);
    check("lost_before_capture", {31'h0, scan_lost}, 32'h1);
    hold(4'b1110, 8'hF9, 1);
    check("lost_cleared", {31'h0, scan_lost}, 32'h0);

    do_reset();
    hold(4'b1110, 8'hF9, 20);
    hold(4'b1101, 8'hA4, 20);
    hold(4'b1011, 8'hB0, 20);
    do_reset();
    fv0 = fv_count;
    scan(8'h92, 8'h82, 8'h40, 8'h80);
    hold(4'hF, 8'hFF, 5);
    check("post_reset_count", 32'(fv_count - fv0), 32'd1);
    check("post_reset_bcd", {16'h0, last_bcd}, 32'h8065);
    check("post_reset_dp", {28'h0, last_dp}, DP_EN ? 32'h4 : 32'h0);
    check("post_reset_err", {31'h0, last_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
